// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - host write and flow-control request bundle for the UART TX scheduler
interface uart_tx_scheduler_if;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       fc_req;
   logic       fc_code;
   logic       fc_ack;

   modport master (
      output wr_valid, wr_data, fc_req, fc_code,
      input  wr_ready, fc_ack
   );

   modport slave (
      input  wr_valid, wr_data, fc_req, fc_code,
      output wr_ready, fc_ack
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - host byte FIFO, XON/XOFF priority arbitration and UART frame serializer
module uart_tx_scheduler #(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] XON_CHAR   = 8'h11,
   parameter logic [7:0] XOFF_CHAR  = 8'h13
) (
   input  logic                        baud_clk,
   input  logic                        rst,
   input  logic [4:0]                  line_control_reg,
   input  logic                        tx_en,
   uart_tx_scheduler_if.slave          host,
   output logic                        tx_out,
   output logic                        busy,
   output logic                        frame_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int             AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push;
   logic          pop_fifo;
   logic          pop_fc;
   logic          arb_point;
   logic          fc_pending;
   logic          fc_code_q;
   logic          fc_ack_q;

   state_t        state;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic [2:0]    n_last;
   logic          par_en;
   logic          par_even;
   logic          two_stop;
   logic          stop_idx;
   logic          par_acc;
   logic          is_fc;

   // The state says which bit goes on the line at the next edge; tx_out is that bit registered,
   // so a frame is visible one cycle after it is selected.
   assign host.wr_ready = (fifo_count != FULL_COUNT);
   assign host.fc_ack   = fc_ack_q;
   assign push          = host.wr_valid && host.wr_ready;
   assign arb_point     = (state == ST_IDLE) || (state == ST_STOP && stop_idx == two_stop);
   assign pop_fc        = arb_point && fc_pending;
   assign pop_fifo      = arb_point && !fc_pending && tx_en && (fifo_count != '0);

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge baud_clk) begin
      if (push) mem[wr_ptr] <= host.wr_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge baud_clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + 1'b1;
         if (pop_fifo) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_fifo})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Pending flow-control request; a new request wins over the clear from a same-cycle pop
   always_ff @(posedge baud_clk) begin
      if (rst) begin
         fc_pending <= 1'b0;
         fc_code_q  <= 1'b0;
      end else if (host.fc_req) begin
         fc_pending <= 1'b1;
         fc_code_q  <= host.fc_code;
      end else if (pop_fc) begin
         fc_pending <= 1'b0;
      end
   end

   // Frame sequencer with registered line, busy and pulse outputs
   always_ff @(posedge baud_clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tx_out     <= 1'b1;
         busy       <= 1'b0;
         fc_ack_q   <= 1'b0;
         frame_done <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         n_last     <= '0;
         par_en     <= 1'b0;
         par_even   <= 1'b0;
         two_stop   <= 1'b0;
         stop_idx   <= 1'b0;
         par_acc    <= 1'b0;
         is_fc      <= 1'b0;
      end else begin
         tx_out     <= 1'b1;
         fc_ack_q   <= 1'b0;
         frame_done <= 1'b0;
         busy       <= (state != ST_IDLE);
         case (state)
            ST_START: begin
               tx_out   <= 1'b0;
               fc_ack_q <= is_fc;
               bit_cnt  <= '0;
               par_acc  <= 1'b0;
               state    <= ST_DATA;
            end
            ST_DATA: begin
               tx_out  <= shreg[0];
               shreg   <= shreg >> 1;
               par_acc <= par_acc ^ shreg[0];
               if (bit_cnt == n_last) begin
                  stop_idx <= 1'b0;
                  state    <= par_en ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               tx_out   <= par_acc ^ ~par_even;
               stop_idx <= 1'b0;
               state    <= ST_STOP;
            end
            ST_STOP: begin
               if (stop_idx == two_stop) frame_done <= 1'b1;
               else                      stop_idx   <= 1'b1;
            end
            ST_IDLE: begin
            end
            default: state <= ST_IDLE;
         endcase
         if (pop_fc || pop_fifo) begin
            shreg    <= pop_fc ? (fc_code_q ? XOFF_CHAR : XON_CHAR) : mem[rd_ptr];
            n_last   <= {1'b1, line_control_reg[1:0]};
            two_stop <= line_control_reg[2];
            par_en   <= line_control_reg[3];
            par_even <= line_control_reg[4];
            is_fc    <= pop_fc;
            state    <= ST_START;
         end else if (arb_point) begin
            state <= ST_IDLE;
         end
      end
   end
endmodule
